parking_gate_ctrl: RTL and testbench
====================================

// Module: parking_gate_ctrl
// PURPOSE
//  Parametrised car-park entry/exit controller with password-gated entry.
//  Tracks occupancy and refuses entry when full. Locks the entry lane for a
//  fixed time after MAX_TRIES wrong passwords. Exit lane runs independently.
// PARAMETERS
//  PW_WIDTH        4      password width in bits
//  PASSWORD        4'hA   accepted password value
//  MAX_TRIES       3      wrong attempts allowed before lockout (>=1)
//  CAPACITY        8      number of parking spaces (>=1)
//  LOCKOUT_CYCLES  16     lockout duration in clk cycles (>=1)
//  localparam CW = $clog2(CAPACITY+1)   occupancy width
// PORTS
//  clk              in   1         clock, rising edge
//  reset_n          in   1         asynchronous, active-low reset
//  sensor_entrance  in   1         car present at entry gate
//  sensor_exit      in   1         car present at exit gate
//  pw_valid         in   1         pw_data valid this cycle (1-cycle strobe)
//  pw_data          in   PW_WIDTH  entered password
//  enter_open       out  1         entry barrier open
//  exit_open        out  1         exit barrier open
//  wrong_pw         out  1         1-cycle pulse per rejected password
//  locked           out  1         entry lane in lockout
//  full             out  1         occupancy == CAPACITY
//  occupancy        out  CW        cars currently inside
// BEHAVIOUR
//  Reset: state IDLE, tries=0, lock counter=0, occupancy=0; all 1-bit
//   outputs 0 (full=0 because occupancy=0). All outputs are registered.
//  Entry FSM (IDLE, WAIT_PW, OPEN, LOCKOUT):
//   IDLE:    sensor_entrance=1 and !full -> WAIT_PW; if full, stay IDLE.
//   WAIT_PW: sensor_entrance=0 -> IDLE, tries cleared (car left).
//            pw_valid and pw_data==PASSWORD -> OPEN, tries cleared.
//            pw_valid and mismatch -> wrong_pw pulse next cycle, tries+1;
//            if tries+1 == MAX_TRIES -> LOCKOUT, lock counter loaded.
//            pw_valid=0 -> stay; no timeout.
//   OPEN:    enter_open=1. sensor_entrance falls to 0 -> occupancy+1,
//            -> IDLE.
//   LOCKOUT: locked=1; pw_valid ignored (no wrong_pw pulses). Stays exactly
//            LOCKOUT_CYCLES cycles, then -> IDLE, tries cleared.
//  Latency: enter_open=1 the cycle after a matching pw_valid is sampled;
//   locked=1 the cycle after the MAX_TRIES-th wrong password.
//  Exit lane: exit_open is set the cycle after sensor_exit=1 is sampled
//   while occupancy>0. It clears the cycle after sensor_exit=0 is sampled,
//   and occupancy is decremented on that same clock edge.
//   sensor_exit with occupancy==0: exit_open stays 0; no decrement.
//  Occupancy: increment and decrement on the same edge -> net unchanged.
//   Never exceeds CAPACITY, never below 0 (guarded, not wrapped).
//  full is updated with occupancy. Becoming full during WAIT_PW does not
//   abort the attempt (only 1 entry lane, so it cannot happen).
//  Async reset mid-operation: all state and outputs return to reset values.
//  Barrier opens and closes immediately; wrong_pw is 0 outside WAIT_PW.
// TESTING
//  1 Reset; entrance=1, pw_valid with 4'hA -> enter_open=1 next cycle;
//    entrance=0 -> occupancy=1, enter_open=0.
//  2 Three pw_valid with 4'h3 -> three wrong_pw pulses; locked=1 for 16
//    cycles, extra pw_valid ignored; then IDLE, correct pw opens gate.
//  3 Fill to 8 cars -> full=1; entrance=1 -> stays IDLE, enter_open=0.
//  4 occupancy=0, sensor_exit=1 -> exit_open=0. After 1 entry, exit cycle
//    -> exit_open pulse, occupancy back to 0.
//  5 Entry completion and exit completion on the same edge -> occupancy
//    unchanged.
//  6 reset_n low during OPEN and during LOCKOUT -> all outputs 0 at once,
//    occupancy=0.

Source files
------------

// File: rtl/parking_gate_ctrl_if.sv
// Car-park gate controller signal bundle: lane sensors and password entry
// from the lane hardware, barrier/status indications back from the controller.
interface parking_gate_ctrl_if #(
   parameter int unsigned PW_WIDTH = 4,
   parameter int unsigned CAPACITY = 8
);
   localparam int unsigned CW = $clog2(CAPACITY + 1);

   logic                sensor_entrance;
   logic                sensor_exit;
   logic                pw_valid;
   logic [PW_WIDTH-1:0] pw_data;
   logic                enter_open;
   logic                exit_open;
   logic                wrong_pw;
   logic                locked;
   logic                full;
   logic [CW-1:0]       occupancy;

   // Lane hardware / stimulus side
   modport master (
      output sensor_entrance, sensor_exit, pw_valid, pw_data,
      input  enter_open, exit_open, wrong_pw, locked, full, occupancy
   );

   // Controller side
   modport slave (
      input  sensor_entrance, sensor_exit, pw_valid, pw_data,
      output enter_open, exit_open, wrong_pw, locked, full, occupancy
   );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Car-park entry/exit controller. Entry lane is password gated with a timed
// lockout after repeated wrong passwords; exit lane runs independently.
// Occupancy is tracked with saturating guards and all outputs are registered.
module parking_gate_ctrl #(
   parameter int unsigned          PW_WIDTH       = 4,
   parameter logic [PW_WIDTH-1:0]  PASSWORD       = 4'hA,
   parameter int unsigned          MAX_TRIES      = 3,
   parameter int unsigned          CAPACITY       = 8,
   parameter int unsigned          LOCKOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   parking_gate_ctrl_if.slave    bus
);
   localparam int unsigned CW = $clog2(CAPACITY + 1);
   localparam int unsigned TW = $clog2(MAX_TRIES + 1);
   localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);

   localparam logic [CW-1:0] CAP_VAL    = CW'(CAPACITY);
   localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES - 1);
   localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCKOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_PW,
      ST_OPEN,
      ST_LOCKOUT
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [TW-1:0]   r_tries;
   logic [TW-1:0]   w_tries_nxt;
   logic [LW-1:0]   r_lock_cnt;
   logic [LW-1:0]   w_lock_cnt_nxt;
   logic [CW-1:0]   r_occ;
   logic [CW-1:0]   w_occ_nxt;

   logic            r_enter_open;
   logic            r_exit_open;
   logic            r_wrong_pw;
   logic            r_locked;
   logic            r_full;

   logic            w_wrong_nxt;
   logic            w_entry_done;
   logic            w_exit_done;
   logic            w_exit_open_nxt;
   logic            w_inc;
   logic            w_dec;

   // Entry lane next-state, try counter and lockout timer
   always_comb begin
      w_state_nxt    = r_state;
      w_tries_nxt    = r_tries;
      w_lock_cnt_nxt = r_lock_cnt;
      w_wrong_nxt    = 1'b0;
      w_entry_done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.sensor_entrance && !r_full)
               w_state_nxt = ST_WAIT_PW;
         end
         ST_WAIT_PW: begin
            if (!bus.sensor_entrance) begin
               w_state_nxt = ST_IDLE;
               w_tries_nxt = '0;
            end else if (bus.pw_valid) begin
               if (bus.pw_data == PASSWORD) begin
                  w_state_nxt = ST_OPEN;
                  w_tries_nxt = '0;
               end else begin
                  w_wrong_nxt = 1'b1;
                  w_tries_nxt = r_tries + 1'b1;
                  if (r_tries == TRIES_LAST) begin
                     w_state_nxt    = ST_LOCKOUT;
                     w_lock_cnt_nxt = LOCK_LOAD;
                  end
               end
            end
         end
         ST_OPEN: begin
            if (!bus.sensor_entrance) begin
               w_entry_done = 1'b1;
               w_state_nxt  = ST_IDLE;
            end
         end
         ST_LOCKOUT: begin
            // Counter is loaded with LOCKOUT_CYCLES-1 so the zero check
            // leaves after exactly LOCKOUT_CYCLES cycles in this state.
            if (r_lock_cnt == '0) begin
               w_state_nxt = ST_IDLE;
               w_tries_nxt = '0;
            end else begin
               w_lock_cnt_nxt = r_lock_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_tries_nxt = '0;
         end
      endcase
   end

   // Exit barrier: opens on a car while occupied, closes when the car has gone
   always_comb begin
      w_exit_open_nxt = r_exit_open;
      w_exit_done     = 1'b0;
      if (!r_exit_open) begin
         if (bus.sensor_exit && (r_occ != '0))
            w_exit_open_nxt = 1'b1;
      end else if (!bus.sensor_exit) begin
         w_exit_open_nxt = 1'b0;
         w_exit_done     = 1'b1;
      end
   end

   // Occupancy update with saturation guards; simultaneous entry/exit cancel
   always_comb begin
      w_inc     = w_entry_done && (r_occ != CAP_VAL);
      w_dec     = w_exit_done && (r_occ != '0);
      w_occ_nxt = r_occ;
      if (w_inc && !w_dec)
         w_occ_nxt = r_occ + 1'b1;
      else if (w_dec && !w_inc)
         w_occ_nxt = r_occ - 1'b1;
   end

   // State and registered outputs, all cleared by asynchronous reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_tries      <= '0;
         r_lock_cnt   <= '0;
         r_occ        <= '0;
         r_enter_open <= 1'b0;
         r_exit_open  <= 1'b0;
         r_wrong_pw   <= 1'b0;
         r_locked     <= 1'b0;
         r_full       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_tries      <= w_tries_nxt;
         r_lock_cnt   <= w_lock_cnt_nxt;
         r_occ        <= w_occ_nxt;
         r_enter_open <= (w_state_nxt == ST_OPEN);
         r_exit_open  <= w_exit_open_nxt;
         r_wrong_pw   <= w_wrong_nxt;
         r_locked     <= (w_state_nxt == ST_LOCKOUT);
         r_full       <= (w_occ_nxt == CAP_VAL);
      end
   end

   assign bus.enter_open = r_enter_open;
   assign bus.exit_open  = r_exit_open;
   assign bus.wrong_pw   = r_wrong_pw;
   assign bus.locked     = r_locked;
   assign bus.full       = r_full;
   assign bus.occupancy  = r_occ;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scenario bench for parking_gate_ctrl: each task drives a stimulus table,
// queues the expected output word per cycle and compares after the run.
// Output word layout: {enter_open, exit_open, wrong_pw, locked, full, occupancy[3:0]}.
module tb_parking_gate_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b1;

   parking_gate_ctrl_if #(.PW_WIDTH(4), .CAPACITY(8)) u_if ();

   parking_gate_ctrl #(
      .PW_WIDTH       (4),
      .PASSWORD       (4'hA),
      .MAX_TRIES      (3),
      .CAPACITY       (8),
      .LOCKOUT_CYCLES (16)
   ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (u_if.slave)
   );

   always #5 clk = ~clk;

   logic [8:0] exp_q[$];
   logic [8:0] act_q[$];
   int n_vec = 0;
   int n_err = 0;

   function automatic logic [8:0] o(input logic eo, input logic xo, input logic wp,
                                    input logic lk, input logic fl, input logic [3:0] occ);
      return {eo, xo, wp, lk, fl, occ};
   endfunction

   function automatic logic [8:0] outs();
      return {u_if.enter_open, u_if.exit_open, u_if.wrong_pw, u_if.locked,
              u_if.full, u_if.occupancy};
   endfunction

   // Drive one cycle of stimulus, queue its expectation, capture DUT after the edge
   task automatic row(input logic se, input logic sx, input logic pv,
                      input logic [3:0] pd, input logic [8:0] e);
      u_if.sensor_entrance = se;
      u_if.sensor_exit     = sx;
      u_if.pw_valid        = pv;
      u_if.pw_data         = pd;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      act_q.push_back(outs());
   endtask

   task automatic idle_inputs();
      u_if.sensor_entrance = 1'b0;
      u_if.sensor_exit     = 1'b0;
      u_if.pw_valid        = 1'b0;
      u_if.pw_data         = 4'h0;
   endtask

   task automatic test_reset();
      logic [8:0] e, a;
      int k;
      idle_inputs();
      #2 reset_n = 1'b0;
      #1;
      exp_q.push_back('0);
      act_q.push_back(outs());
      @(posedge clk);
      #1;
      exp_q.push_back('0);
      act_q.push_back(outs());
      @(negedge clk);
      reset_n = 1'b1;
      k = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = act_q.pop_front();
         n_vec++;
         if (a !== e) begin
            n_err++;
            $display("FAIL reset[%0d]: got %b, expected %b", k, a, e);
         end
         k++;
      end
   endtask

   task automatic test_entry();
      logic [8:0] e, a;
      int k;
      row(1, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 0));
      row(1, 0, 1, 4'hA, o(1, 0, 0, 0, 0, 0));
      row(1, 0, 0, 4'h0, o(1, 0, 0, 0, 0, 0));
      row(0, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 1));
      row(0, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 1));
      k = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = act_q.pop_front();
         n_vec++;
         if (a !== e) begin
            n_err++;
            $display("FAIL entry[%0d]: got %b, expected %b", k, a, e);
         end
         k++;
      end
   endtask

   task automatic test_lockout();
      logic [8:0] e, a;
      int k;
      row(1, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 1));
      row(1, 0, 1, 4'h3, o(0, 0, 1, 0, 0, 1));
      row(1, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 1));
      row(1, 0, 1, 4'h3, o(0, 0, 1, 0, 0, 1));
      row(1, 0, 1, 4'h3, o(0, 0, 1, 1, 0, 1));
      for (int i = 0; i < 15; i++)
         row(1, 0, (i % 2) == 0, 4'h3, o(0, 0, 0, 1, 0, 1));
      row(1, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 1));
      row(1, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 1));
      row(1, 0, 1, 4'h3, o(0, 0, 1, 0, 0, 1));
      row(1, 0, 1, 4'hA, o(1, 0, 0, 0, 0, 1));
      row(0, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 2));
      k = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = act_q.pop_front();
         n_vec++;
         if (a !== e) begin
            n_err++;
            $display("FAIL lockout[%0d]: got %b, expected %b", k, a, e);
         end
         k++;
      end
   endtask

   task automatic test_exit();
      logic [8:0] e, a;
      int k;
      row(0, 1, 0, 4'h0, o(0, 1, 0, 0, 0, 2));
      row(0, 1, 0, 4'h0, o(0, 1, 0, 0, 0, 2));
      row(0, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 1));
      row(0, 1, 0, 4'h0, o(0, 1, 0, 0, 0, 1));
      row(0, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 0));
      row(0, 1, 0, 4'h0, o(0, 0, 0, 0, 0, 0));
      row(0, 1, 0, 4'h0, o(0, 0, 0, 0, 0, 0));
      row(0, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 0));
      row(1, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 0));
      row(1, 0, 1, 4'hA, o(1, 0, 0, 0, 0, 0));
      row(0, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 1));
      row(0, 1, 0, 4'h0, o(0, 1, 0, 0, 0, 1));
      row(0, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 0));
      k = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = act_q.pop_front();
         n_vec++;
         if (a !== e) begin
            n_err++;
            $display("FAIL exit[%0d]: got %b, expected %b", k, a, e);
         end
         k++;
      end
   endtask

   task automatic test_simultaneous();
      logic [8:0] e, a;
      int k;
      row(1, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 0));
      row(1, 0, 1, 4'hA, o(1, 0, 0, 0, 0, 0));
      row(0, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 1));
      row(1, 1, 0, 4'h0, o(0, 1, 0, 0, 0, 1));
      row(1, 1, 1, 4'hA, o(1, 1, 0, 0, 0, 1));
      row(0, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 1));
      row(0, 1, 0, 4'h0, o(0, 1, 0, 0, 0, 1));
      row(0, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 0));
      k = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = act_q.pop_front();
         n_vec++;
         if (a !== e) begin
            n_err++;
            $display("FAIL simultaneous[%0d]: got %b, expected %b", k, a, e);
         end
         k++;
      end
   endtask

   task automatic test_full();
      logic [8:0] e, a;
      int k;
      for (int c = 0; c < 8; c++) begin
         row(1, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 4'(c)));
         row(1, 0, 1, 4'hA, o(1, 0, 0, 0, 0, 4'(c)));
         row(0, 0, 0, 4'h0, o(0, 0, 0, 0, (c == 7), 4'(c + 1)));
      end
      row(1, 0, 0, 4'h0, o(0, 0, 0, 0, 1, 8));
      row(1, 0, 1, 4'hA, o(0, 0, 0, 0, 1, 8));
      row(1, 0, 0, 4'h0, o(0, 0, 0, 0, 1, 8));
      row(0, 1, 0, 4'h0, o(0, 1, 0, 0, 1, 8));
      row(0, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 7));
      row(1, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 7));
      row(1, 0, 1, 4'hA, o(1, 0, 0, 0, 0, 7));
      row(0, 0, 0, 4'h0, o(0, 0, 0, 0, 1, 8));
      k = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = act_q.pop_front();
         n_vec++;
         if (a !== e) begin
            n_err++;
            $display("FAIL full[%0d]: got %b, expected %b", k, a, e);
         end
         k++;
      end
   endtask

   task automatic test_reset_mid_op();
      logic [8:0] e, a;
      int k;
      // Free a space, then reset while the entry barrier is open
      row(0, 1, 0, 4'h0, o(0, 1, 0, 0, 1, 8));
      row(0, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 7));
      row(1, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 7));
      row(1, 0, 1, 4'hA, o(1, 0, 0, 0, 0, 7));
      #2 reset_n = 1'b0;
      #1;
      exp_q.push_back('0);
      act_q.push_back(outs());
      idle_inputs();
      @(negedge clk);
      reset_n = 1'b1;
      // Drive into lockout, then reset
      row(1, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 0));
      row(1, 0, 1, 4'h3, o(0, 0, 1, 0, 0, 0));
      row(1, 0, 1, 4'h3, o(0, 0, 1, 0, 0, 0));
      row(1, 0, 1, 4'h3, o(0, 0, 1, 1, 0, 0));
      row(1, 0, 0, 4'h0, o(0, 0, 0, 1, 0, 0));
      #2 reset_n = 1'b0;
      #1;
      exp_q.push_back('0);
      act_q.push_back(outs());
      idle_inputs();
      @(negedge clk);
      reset_n = 1'b1;
      // Normal entry afterwards: try counter must be clear
      row(1, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 0));
      row(1, 0, 1, 4'hA, o(1, 0, 0, 0, 0, 0));
      row(0, 0, 0, 4'h0, o(0, 0, 0, 0, 0, 1));
      k = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = act_q.pop_front();
         n_vec++;
         if (a !== e) begin
            n_err++;
            $display("FAIL reset_mid_op[%0d]: got %b, expected %b", k, a, e);
         end
         k++;
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_entry();
      test_lockout();
      test_exit();
      test_simultaneous();
      test_full();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
